// File: rtl/rf_write_sequencer.sv
// Register file write port sequencer: merges pipeline WB with a queued
// long-latency aux unit and tracks pending aux destinations.
module rf_write_sequencer #(
    parameter int WORD_W = 32,
    parameter int QDEPTH = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wb_valid,
    input  logic [4:0]        wb_sel,
    input  logic [WORD_W-1:0] wb_dat,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [4:0]        aux_sel,
    input  logic [WORD_W-1:0] aux_dat,
    output logic              rf_WEN,
    output logic [4:0]        rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic [31:0]       busy_mask
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]        q_sel [QDEPTH];
    logic [WORD_W-1:0] q_dat [QDEPTH];
    logic [QDEPTH-1:0] q_live;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              wb_win;
    logic              pop;
    logic              push;
    logic [QDEPTH-1:0] queued;
    logic [PW-1:0]     off [QDEPTH];

    assign aux_ready = nRST && (count != CW'(QDEPTH));
    assign wb_win    = wb_valid && (wb_sel != 5'd0);
    assign pop       = !wb_win && (count != '0);
    assign push      = aux_valid && aux_ready;

    // A slot holds a queued entry when its distance from the head is
    // below the occupancy count.
    for (genvar g = 0; g < QDEPTH; g++) begin : g_occ
        assign off[g]    = PW'(g) - rd_ptr;
        assign queued[g] = {1'b0, off[g]} < count;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (queued[i] && q_live[i]) begin
                busy_mask[q_sel[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            q_live <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_sel[i] <= '0;
                q_dat[i] <= '0;
            end
        end else begin
            // WB write is younger than every queued aux write to the
            // same register; the push below overrides for the new slot.
            if (wb_win) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (q_sel[i] == wb_sel) begin
                        q_live[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                q_sel[wr_ptr]  <= aux_sel;
                q_dat[wr_ptr]  <= aux_dat;
                q_live[wr_ptr] <= (aux_sel != 5'd0);
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_WEN  <= 1'b0;
            rf_wsel <= '0;
            rf_wdat <= '0;
        end else begin
            unique case (1'b1)
                wb_win: begin
                    rf_WEN  <= 1'b1;
                    rf_wsel <= wb_sel;
                    rf_wdat <= wb_dat;
                end
                pop: begin
                    rf_WEN  <= q_live[rd_ptr];
                    rf_wsel <= q_sel[rd_ptr];
                    rf_wdat <= q_dat[rd_ptr];
                end
                default: begin
                    rf_WEN  <= 1'b0;
                    rf_wsel <= '0;
                    rf_wdat <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_write_sequencer.md
Name: rf_write_sequencer

Overview:
Initiator on the register file write port. Merges two writeback sources onto the single rf write port (WEN/wsel/wdat):
- the in-order pipeline WB stage, which is never stalled;
- a long-latency auxiliary unit (mult/div), buffered in a small FIFO.

It also exports a pending-write mask so decode can stall on registers with outstanding aux results.

Parameters:
WORD_W, 32, data word width
QDEPTH, 4, aux FIFO entries (power of two, >=2)

Ports:
CLK  in  1  clock; rf_* outputs update on posedge, the register file commits on the following negedge
nRST  in  1  reset
wb_valid  in  1  pipeline writeback request this cycle
wb_sel  in  5  pipeline destination register
wb_dat  in  WORD_W  pipeline write data
aux_valid  in  1  aux result offered
aux_ready  out  1  aux result accepted when aux_valid && aux_ready
aux_sel  in  5  aux destination register
aux_dat  in  WORD_W  aux write data
rf_WEN  out  1  register file write enable
rf_wsel  out  5  register file write select
rf_wdat  out  WORD_W  register file write data
busy_mask  out  32  bit r=1 while a live queued aux entry targets register r

Behaviour:
- Reset: nRST, asynchronous, active-low.
  - While low: rf_WEN=0, rf_wsel=0, rf_wdat=0, FIFO empty (rd/wr pointers 0, count 0), all live bits 0, busy_mask=0, aux_ready=0.
  - Reset mid-operation discards all queued entries with no rf write.
- aux_ready = nRST && (count != QDEPTH).
  - Registered-count based; no same-cycle pass-through when full, even if a pop occurs that cycle.
- Enqueue: on aux_valid && aux_ready, write {sel, dat, live} at wr_ptr; wr_ptr and count advance.
  - live = (aux_sel != 0). An aux write to $0 is accepted and consumed silently.
- Per-cycle slot selection (one rf write per cycle):
  - wb_valid && wb_sel != 0: the WB request wins the slot.
  - Otherwise, if count > 0: pop the FIFO head. A live head is written; a non-live (squashed) head uses the slot with no write.
  - Otherwise: idle.
- Output timing: the selected request drives rf_* registered at the next posedge (latency 1), so the value is committed in the register file at the negedge of that cycle. rf_WEN=0 for idle slots, non-live pops, and wb_sel==0.
- WB squash (ordering rule): a WB write to r is younger than any queued aux write to r.
  - In the cycle a WB write to r wins the slot, clear live on every queued entry with sel==r.
  - An aux entry enqueued in that same cycle with sel==r is not squashed; it is younger.
- busy_mask = OR over queued entries of (live ? onehot(sel) : 0), computed combinationally from FIFO state. Bit 0 is always 0.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Pointers wrap modulo QDEPTH.
- Sustained WB traffic starves the FIFO indefinitely. Software/pipeline guarantees gaps; the block must not drop or reorder entries during starvation.

Test Plan:
- Reset: assert nRST=0 mid-drain with 3 entries queued -> rf_WEN=0 immediately; aux_ready=0 during reset; after release aux_ready=1, busy_mask=0, no stale writes ever appear.
- WB only: wb_valid=1, sel=5, dat=0xDEADBEEF at cycle N -> cycle N+1 rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF; wb_sel=0 -> rf_WEN=0.
- Aux drain order: enqueue (3,0x11),(7,0x22) with wb_valid=0 -> busy_mask=0x88, then writes r3=0x11 then r7=0x22 on consecutive cycles, busy_mask returns to 0.
- Full/backpressure: hold wb_valid=1 (sel=1) while pushing 5 aux results -> aux_ready drops after 4 accepted; the 5th is held until the first pop; drain order preserved across pointer wrap.
- Squash: queue aux (9,0xAA), then WB (9,0xBB) wins the slot -> busy_mask bit 9 clears that cycle; rf writes r9=0xBB only; the later pop of the squashed entry gives rf_WEN=0.
- Same-cycle squash boundary: WB sel=4 and aux enqueue sel=4 in the same cycle -> the aux entry stays live; r4 is written with WB data first, then with aux data.
